// File: rtl/product_accumulator.sv
// Accumulates LEN signed products per block, one per rising edge of done,
// with saturating add and a valid/ready handshake on the finished sum.
module product_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+4,
    parameter int LEN   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       done,
    input  logic [2*N-1:0]             p,
    output logic [ACC_W-1:0]           sum,
    output logic                       sum_valid,
    input  logic                       sum_ready,
    output logic                       ovf,
    output logic                       busy,
    output logic [$clog2(LEN+1)-1:0]   count
);

    localparam int PW = 2*N;
    localparam int CW = $clog2(LEN+1);
    localparam logic [CW-1:0]    LAST = CW'(LEN-1);
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_sum;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_busy;
    logic              r_valid;
    logic              r_done_d;

    logic              w_edge;
    logic [ACC_W:0]    w_ext;
    logic [ACC_W:0]    w_acc;
    logic [ACC_W:0]    w_add;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_sat;

    assign w_edge = done & ~r_done_d;

    // One guard bit: the sum overflowed iff the top two bits disagree.
    assign w_ext = {{(ACC_W+1-PW){p[PW-1]}}, p};
    assign w_acc = {r_sum[ACC_W-1], r_sum};
    assign w_add = w_acc + w_ext;
    assign w_ovf = w_add[ACC_W] ^ w_add[ACC_W-1];
    assign w_sat = w_ovf ? (w_add[ACC_W] ? SMIN : SMAX)
                         : w_add[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sum    <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done_d <= 1'b1;
        end else begin
            r_done_d <= done;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sum   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (start) begin
                        r_sum   <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end else if (w_edge) begin
                        r_sum   <= w_sat;
                        r_ovf   <= r_ovf | w_ovf;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST) begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (sum_ready) begin
                        r_valid <= 1'b0;
                        if (start) begin
                            r_sum   <= '0;
                            r_count <= '0;
                            r_ovf   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ACCUM;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign busy      = r_busy;
    assign sum_valid = r_valid;

endmodule
